// File: rtl/cs_mseq_pkg.sv
// ---------------------------------------------------------------------------
// cs_mseq_pkg
// Shared definitions for the microsequencer slice: control-store geometry,
// MIR COND field encodings, sequencer state encodings and the bit positions
// used to build a DECODE dispatch address from the macroinstruction.
// Ports: none (package).
// ---------------------------------------------------------------------------
package cs_mseq_pkg;

    localparam int CS_ADDR_W  = 11;
    localparam int CS_COND_W  = 3;
    localparam int CS_INSTR_W = 32;
    localparam int CS_PSR_W   = 4;

    // MIR COND field: how the next microaddress is chosen
    typedef enum logic [CS_COND_W-1:0] {
        COND_NEXT   = 3'b000,
        COND_N      = 3'b001,
        COND_Z      = 3'b010,
        COND_V      = 3'b011,
        COND_C      = 3'b100,
        COND_IR13   = 3'b101,
        COND_JUMP   = 3'b110,
        COND_DECODE = 3'b111
    } condCode_t;

    // Sequencer states, also exported on the debug state output
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_FETCH = 2'b01;
    localparam logic [1:0] ST_EXEC  = 2'b10;
    localparam logic [1:0] ST_WAIT  = 2'b11;

    // PSR bit positions inside {n,z,v,c}
    localparam int PSR_N = 3;
    localparam int PSR_Z = 2;
    localparam int PSR_V = 1;
    localparam int PSR_C = 0;

    // DECODE dispatch fields: op in IR[31:30], op3 in IR[24:19]
    localparam int DEC_OP_MSB    = 31;
    localparam int DEC_OP_LSB    = 30;
    localparam int DEC_OP3_MSB   = 24;
    localparam int DEC_OP3_LSB   = 19;
    localparam int IR_BRANCH_BIT = 13;

    // Dispatch address: upper half of the control store, 4-word slots per opcode
    function automatic logic [CS_ADDR_W-1:0] decodeAddr(input logic [CS_INSTR_W-1:0] ir);
        return {1'b1, ir[DEC_OP_MSB:DEC_OP_LSB], ir[DEC_OP3_MSB:DEC_OP3_LSB], 2'b00};
    endfunction

endpackage

// File: rtl/cs_mseq_if.sv
// ---------------------------------------------------------------------------
// cs_mseq_if
// Bundle of MIR fields, status inputs and sequencer outputs around cs_mseq.
// Inputs to the sequencer: COND, ADDRESS, RD, WR, PSR {n,z,v,c}, IR, MEMREADY.
// Outputs from the sequencer: MPC, MIRload (active-low), EXEC strobe,
// debug STATE, sticky TIMEOUT flag.
// Modports: master (drives MIR/status, observes sequencer), slave (cs_mseq).
// ---------------------------------------------------------------------------
interface cs_mseq_if
    import cs_mseq_pkg::*;
#(
    parameter int ADDR_W  = CS_ADDR_W,
    parameter int COND_W  = CS_COND_W,
    parameter int INSTR_W = CS_INSTR_W
) ();

    logic [COND_W-1:0]   CS_MSEQ_COND_data_InBUS;
    logic [ADDR_W-1:0]   CS_MSEQ_ADDRESS_data_InBUS;
    logic                CS_MSEQ_RD_data_In;
    logic                CS_MSEQ_WR_data_In;
    logic [CS_PSR_W-1:0] CS_MSEQ_PSR_data_InBUS;
    logic [INSTR_W-1:0]  CS_MSEQ_IR_data_InBUS;
    logic                CS_MSEQ_MEMREADY_InHigh;
    logic [ADDR_W-1:0]   CS_MSEQ_MPC_data_OutBUS;
    logic                CS_MSEQ_MIRload_OutLow;
    logic                CS_MSEQ_EXEC_Out;
    logic [1:0]          CS_MSEQ_STATE_OutBUS;
    logic                CS_MSEQ_TIMEOUT_Out;

    modport master (
        output CS_MSEQ_COND_data_InBUS, CS_MSEQ_ADDRESS_data_InBUS,
               CS_MSEQ_RD_data_In, CS_MSEQ_WR_data_In,
               CS_MSEQ_PSR_data_InBUS, CS_MSEQ_IR_data_InBUS,
               CS_MSEQ_MEMREADY_InHigh,
        input  CS_MSEQ_MPC_data_OutBUS, CS_MSEQ_MIRload_OutLow,
               CS_MSEQ_EXEC_Out, CS_MSEQ_STATE_OutBUS, CS_MSEQ_TIMEOUT_Out
    );

    modport slave (
        input  CS_MSEQ_COND_data_InBUS, CS_MSEQ_ADDRESS_data_InBUS,
               CS_MSEQ_RD_data_In, CS_MSEQ_WR_data_In,
               CS_MSEQ_PSR_data_InBUS, CS_MSEQ_IR_data_InBUS,
               CS_MSEQ_MEMREADY_InHigh,
        output CS_MSEQ_MPC_data_OutBUS, CS_MSEQ_MIRload_OutLow,
               CS_MSEQ_EXEC_Out, CS_MSEQ_STATE_OutBUS, CS_MSEQ_TIMEOUT_Out
    );

endinterface

// File: rtl/cs_mseq_next_addr.sv
// ---------------------------------------------------------------------------
// cs_mseq_next_addr
// Purely combinational next-microaddress selector.
// Ports:
//   i_cond     MIR COND field
//   i_address  MIR jump address
//   i_psr      flags {n,z,v,c}
//   i_ir       current macroinstruction
//   i_mpc      current micro PC
//   o_nextAddr microaddress to load on commit
// ---------------------------------------------------------------------------
module cs_mseq_next_addr
    import cs_mseq_pkg::*;
#(
    parameter int ADDR_W  = CS_ADDR_W,
    parameter int COND_W  = CS_COND_W,
    parameter int INSTR_W = CS_INSTR_W
) (
    input  logic [COND_W-1:0]   i_cond,
    input  logic [ADDR_W-1:0]   i_address,
    input  logic [CS_PSR_W-1:0] i_psr,
    input  logic [INSTR_W-1:0]  i_ir,
    input  logic [ADDR_W-1:0]   i_mpc,
    output logic [ADDR_W-1:0]   o_nextAddr
);

    logic [ADDR_W-1:0] w_seqAddr;
    logic              w_unusedIrBits;

    // Sequential successor wraps naturally at the top of the control store
    assign w_seqAddr = i_mpc + ADDR_W'(1);

    // IR bits that play no part in sequencing, gathered into one sink
    assign w_unusedIrBits = ^{i_ir[29:25], i_ir[18:14], i_ir[12:0]};

    // Pick the successor: conditional branches fall through to MPC+1,
    // JUMP always takes ADDRESS, DECODE dispatches on the opcode fields
    always_comb begin
        o_nextAddr = w_seqAddr;
        case (i_cond)
            COND_NEXT:   o_nextAddr = w_seqAddr;
            COND_N:      o_nextAddr = i_psr[PSR_N] ? i_address : w_seqAddr;
            COND_Z:      o_nextAddr = i_psr[PSR_Z] ? i_address : w_seqAddr;
            COND_V:      o_nextAddr = i_psr[PSR_V] ? i_address : w_seqAddr;
            COND_C:      o_nextAddr = i_psr[PSR_C] ? i_address : w_seqAddr;
            COND_IR13:   o_nextAddr = i_ir[IR_BRANCH_BIT] ? i_address : w_seqAddr;
            COND_JUMP:   o_nextAddr = i_address;
            COND_DECODE: o_nextAddr = decodeAddr(i_ir);
            default:     o_nextAddr = w_seqAddr;
        endcase
    end

endmodule

// File: rtl/cs_mseq.sv
// ---------------------------------------------------------------------------
// cs_mseq
// Microsequencer: owns the micro PC, sequences IDLE -> FETCH -> EXEC
// (-> WAIT while a memory access is outstanding) and commits one
// microinstruction per EXEC pulse.
// Optional feature macro: CS_MSEQ_TIMEOUT_EN bounds WAIT at TIMEOUT_CYCLES
// and traps to TRAP_ADDR, raising a sticky timeout flag.
// Ports:
//   CS_MSEQ_CLOCK_50     system clock, rising edge
//   CS_MSEQ_RESET_InLow  asynchronous active-low reset
//   bus                  cs_mseq_if.slave (MIR fields, flags, IR, MEMREADY in;
//                        MPC, MIRload_n, EXEC strobe, STATE, TIMEOUT out)
// ---------------------------------------------------------------------------
module cs_mseq
    import cs_mseq_pkg::*;
#(
    parameter int ADDR_W         = CS_ADDR_W,
    parameter int COND_W         = CS_COND_W,
    parameter int INSTR_W        = CS_INSTR_W,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TRAP_ADDR      = 2047
) (
    input logic       CS_MSEQ_CLOCK_50,
    input logic       CS_MSEQ_RESET_InLow,
    cs_mseq_if.slave  bus
);

    logic [1:0]        r_state;
    logic [1:0]        w_stateNext;
    logic [ADDR_W-1:0] r_mpc;
    logic [ADDR_W-1:0] w_nextAddr;
    logic              w_memOp;
    logic              w_commit;
    logic              w_trap;

    // RD and WR together still form a single handshake
    assign w_memOp = bus.CS_MSEQ_RD_data_In | bus.CS_MSEQ_WR_data_In;

    cs_mseq_next_addr #(
        .ADDR_W  (ADDR_W),
        .COND_W  (COND_W),
        .INSTR_W (INSTR_W)
    ) u_nextAddr (
        .i_cond     (bus.CS_MSEQ_COND_data_InBUS),
        .i_address  (bus.CS_MSEQ_ADDRESS_data_InBUS),
        .i_psr      (bus.CS_MSEQ_PSR_data_InBUS),
        .i_ir       (bus.CS_MSEQ_IR_data_InBUS),
        .i_mpc      (r_mpc),
        .o_nextAddr (w_nextAddr)
    );

`ifdef CS_MSEQ_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] r_waitCount;
    logic             r_timeout;

    // Trap fires in the WAIT cycle that completes the budget; a MEMREADY in
    // that same cycle wins because the commit path is checked first
    assign w_trap = (r_state == ST_WAIT) && !bus.CS_MSEQ_MEMREADY_InHigh
                    && (r_waitCount == CNT_W'(TIMEOUT_CYCLES - 1));

    // Count WAIT cycles already spent; cleared whenever WAIT is left
    always_ff @(posedge CS_MSEQ_CLOCK_50 or negedge CS_MSEQ_RESET_InLow) begin
        if (!CS_MSEQ_RESET_InLow) begin
            r_waitCount <= '0;
        end else if ((r_state == ST_WAIT) && (w_stateNext == ST_WAIT)) begin
            r_waitCount <= r_waitCount + 1'b1;
        end else begin
            r_waitCount <= '0;
        end
    end

    // Timeout flag stays set until the next reset so software can inspect it
    always_ff @(posedge CS_MSEQ_CLOCK_50 or negedge CS_MSEQ_RESET_InLow) begin
        if (!CS_MSEQ_RESET_InLow) begin
            r_timeout <= 1'b0;
        end else if (w_trap) begin
            r_timeout <= 1'b1;
        end
    end

    assign bus.CS_MSEQ_TIMEOUT_Out = r_timeout;
`else
    logic [31:0] w_unusedTimeoutCycles;

    // Without the watchdog WAIT is unbounded and the flag never rises
    assign w_trap                  = 1'b0;
    assign bus.CS_MSEQ_TIMEOUT_Out = 1'b0;
    assign w_unusedTimeoutCycles   = TIMEOUT_CYCLES;
`endif

    // Next-state and commit decision; MEMREADY only matters in EXEC/WAIT
    always_comb begin
        w_commit    = 1'b0;
        w_stateNext = r_state;
        case (r_state)
            ST_IDLE: begin
                w_stateNext = ST_FETCH;
            end
            ST_FETCH: begin
                w_stateNext = ST_EXEC;
            end
            ST_EXEC: begin
                if (!w_memOp || bus.CS_MSEQ_MEMREADY_InHigh) begin
                    w_commit    = 1'b1;
                    w_stateNext = ST_FETCH;
                end else begin
                    w_stateNext = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.CS_MSEQ_MEMREADY_InHigh) begin
                    w_commit    = 1'b1;
                    w_stateNext = ST_FETCH;
                end else if (w_trap) begin
                    w_stateNext = ST_FETCH;
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge CS_MSEQ_CLOCK_50 or negedge CS_MSEQ_RESET_InLow) begin
        if (!CS_MSEQ_RESET_InLow) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // MPC only moves on a commit or a trap, so it still addresses the current
    // microinstruction throughout EXEC/WAIT
    always_ff @(posedge CS_MSEQ_CLOCK_50 or negedge CS_MSEQ_RESET_InLow) begin
        if (!CS_MSEQ_RESET_InLow) begin
            r_mpc <= '0;
        end else if (w_commit) begin
            r_mpc <= w_nextAddr;
        end else if (w_trap) begin
            r_mpc <= ADDR_W'(TRAP_ADDR);
        end
    end

    assign bus.CS_MSEQ_MPC_data_OutBUS = r_mpc;
    assign bus.CS_MSEQ_MIRload_OutLow  = (r_state != ST_FETCH);
    assign bus.CS_MSEQ_EXEC_Out        = w_commit;
    assign bus.CS_MSEQ_STATE_OutBUS    = r_state;

endmodule

// File: tb/tb_cs_mseq.sv
// ---------------------------------------------------------------------------
// tb_cs_mseq
// Directed bench for cs_mseq. The bench plays the role of the control store:
// it drives MIR fields during FETCH, expected successor addresses go into a
// queue when each microinstruction is issued and are popped when the
// sequencer returns to FETCH. Build with CS_MSEQ_TIMEOUT_EN to exercise the
// watchdog trap; otherwise a long WAIT checks that nothing traps.
// ---------------------------------------------------------------------------
module tb_cs_mseq;
    import cs_mseq_pkg::*;

    localparam int TB_TIMEOUT = 4;

    logic        clock = 1'b0;
    logic        resetInLow = 1'b0;
    int          checks = 0;
    int          errors = 0;
    logic [10:0] expQ[$];
    logic [10:0] modelMpc = '0;
    logic [10:0] popped;

    // 10-unit clock; inputs change and outputs are sampled on the falling edge
    always #5 clock = ~clock;

    cs_mseq_if busIf ();

    cs_mseq #(
        .TIMEOUT_CYCLES (TB_TIMEOUT),
        .TRAP_ADDR      (2047)
    ) dut (
        .CS_MSEQ_CLOCK_50    (clock),
        .CS_MSEQ_RESET_InLow (resetInLow),
        .bus                 (busIf)
    );

    // One comparison: counted, and reported with tag/observed/expected on failure
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Present a microinstruction's fields plus flags/IR/MEMREADY
    task automatic applyStimulus(input logic [2:0] cond, input logic [10:0] addr,
                                 input logic rd, input logic wr, input logic [3:0] psr,
                                 input logic [31:0] ir, input logic ready);
        busIf.CS_MSEQ_COND_data_InBUS    = cond;
        busIf.CS_MSEQ_ADDRESS_data_InBUS = addr;
        busIf.CS_MSEQ_RD_data_In         = rd;
        busIf.CS_MSEQ_WR_data_In         = wr;
        busIf.CS_MSEQ_PSR_data_InBUS     = psr;
        busIf.CS_MSEQ_IR_data_InBUS      = ir;
        busIf.CS_MSEQ_MEMREADY_InHigh    = ready;
    endtask

    task automatic nextCycle();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Issue one microinstruction starting at a FETCH-cycle falling edge.
    // waitCycles>0 means MEMREADY stays low in EXEC and rises in the last WAIT cycle.
    task automatic runMicro(input string tag, input logic [2:0] cond, input logic [10:0] addr,
                            input logic rd, input logic wr, input logic [3:0] psr,
                            input logic [31:0] ir, input int waitCycles,
                            input logic [10:0] expNext);
        checkOutput({tag, ".fetchState"}, 32'(busIf.CS_MSEQ_STATE_OutBUS), 32'(ST_FETCH));
        checkOutput({tag, ".mirLoadLow"}, 32'(busIf.CS_MSEQ_MIRload_OutLow), 32'd0);
        checkOutput({tag, ".mpcAtFetch"}, 32'(busIf.CS_MSEQ_MPC_data_OutBUS), 32'(modelMpc));
        expQ.push_back(expNext);
        applyStimulus(cond, addr, rd, wr, psr, ir, waitCycles == 0);
        nextCycle();
        checkOutput({tag, ".execState"}, 32'(busIf.CS_MSEQ_STATE_OutBUS), 32'(ST_EXEC));
        checkOutput({tag, ".execPulse"}, 32'(busIf.CS_MSEQ_EXEC_Out), 32'(waitCycles == 0));
        for (int i = 1; i <= waitCycles; i++) begin
            nextCycle();
            checkOutput({tag, ".waitState"}, 32'(busIf.CS_MSEQ_STATE_OutBUS), 32'(ST_WAIT));
            checkOutput({tag, ".mpcHeld"}, 32'(busIf.CS_MSEQ_MPC_data_OutBUS), 32'(modelMpc));
            checkOutput({tag, ".noEarlyPulse"}, 32'(busIf.CS_MSEQ_EXEC_Out), 32'd0);
            if (i == waitCycles) begin
                busIf.CS_MSEQ_MEMREADY_InHigh = 1'b1;
                #1;
                checkOutput({tag, ".readyPulse"}, 32'(busIf.CS_MSEQ_EXEC_Out), 32'd1);
            end
        end
        nextCycle();
        applyStimulus(3'b000, 11'd0, 1'b0, 1'b0, 4'b0000, 32'd0, 1'b0);
        popped = expQ.pop_front();
        checkOutput({tag, ".mpcNext"}, 32'(busIf.CS_MSEQ_MPC_data_OutBUS), 32'(popped));
        checkOutput({tag, ".pulseDone"}, 32'(busIf.CS_MSEQ_EXEC_Out), 32'd0);
        modelMpc = popped;
    endtask

    // Directed sequence: reset, sequencing, branches, decode, stalls, timeout, reset mid-WAIT
    initial begin
        $display("[TB] cs_mseq directed run starting");
        applyStimulus(3'b000, 11'd0, 1'b0, 1'b0, 4'b0000, 32'd0, 1'b0);
        repeat (3) @(negedge clock);
        checkOutput("reset.mpc",     32'(busIf.CS_MSEQ_MPC_data_OutBUS), 32'd0);
        checkOutput("reset.mirLoad", 32'(busIf.CS_MSEQ_MIRload_OutLow), 32'd1);
        checkOutput("reset.exec",    32'(busIf.CS_MSEQ_EXEC_Out), 32'd0);
        checkOutput("reset.state",   32'(busIf.CS_MSEQ_STATE_OutBUS), 32'(ST_IDLE));
        checkOutput("reset.timeout", 32'(busIf.CS_MSEQ_TIMEOUT_Out), 32'd0);

        // Released between edges: still IDLE until the next rising edge
        resetInLow = 1'b1;
        #1;
        checkOutput("release.idle", 32'(busIf.CS_MSEQ_STATE_OutBUS), 32'(ST_IDLE));
        nextCycle();
        modelMpc = 11'd0;

        runMicro("jump5",     3'b110, 11'd5,    1'b0, 1'b0, 4'b0000, 32'd0, 0, 11'd5);
        runMicro("seq5",      3'b000, 11'd77,   1'b0, 1'b0, 4'b1111, 32'd0, 0, 11'd6);
        runMicro("jump2047",  3'b110, 11'd2047, 1'b0, 1'b0, 4'b0000, 32'd0, 0, 11'd2047);
        runMicro("wrap",      3'b000, 11'd300,  1'b0, 1'b0, 4'b0000, 32'd0, 0, 11'd0);
        runMicro("zTaken",    3'b010, 11'd100,  1'b0, 1'b0, 4'b0100, 32'd0, 0, 11'd100);
        runMicro("jump7",     3'b110, 11'd7,    1'b0, 1'b0, 4'b0000, 32'd0, 0, 11'd7);
        runMicro("zNotTaken", 3'b010, 11'd100,  1'b0, 1'b0, 4'b1011, 32'd0, 0, 11'd8);
        runMicro("nTaken",    3'b001, 11'd300,  1'b0, 1'b0, 4'b1000, 32'd0, 0, 11'd300);
        runMicro("cNotTaken", 3'b100, 11'd999,  1'b0, 1'b0, 4'b1110, 32'd0, 0, 11'd301);
        runMicro("ir13Taken", 3'b101, 11'd1234, 1'b0, 1'b0, 4'b0000, 32'h0000_2000, 0, 11'd1234);
        runMicro("vTaken",    3'b011, 11'd40,   1'b0, 1'b0, 4'b0010, 32'd0, 0, 11'd40);
        runMicro("decode",    3'b111, 11'd5,    1'b0, 1'b0, 4'b0000, 32'hC020_0000, 0, 11'd1808);
        runMicro("rdStall",   3'b000, 11'd0,    1'b1, 1'b0, 4'b0000, 32'd0, 3, 11'd1809);
        runMicro("rdWrReady", 3'b000, 11'd0,    1'b1, 1'b1, 4'b0000, 32'd0, 0, 11'd1810);
        runMicro("wrStall",   3'b110, 11'd3,    1'b0, 1'b1, 4'b0000, 32'd0, 1, 11'd3);

`ifdef CS_MSEQ_TIMEOUT_EN
        // WR with MEMREADY never arriving: trap after TB_TIMEOUT WAIT cycles
        checkOutput("trap.fetchState", 32'(busIf.CS_MSEQ_STATE_OutBUS), 32'(ST_FETCH));
        expQ.push_back(11'd2047);
        applyStimulus(3'b000, 11'd0, 1'b0, 1'b1, 4'b0000, 32'd0, 1'b0);
        nextCycle();
        checkOutput("trap.execState", 32'(busIf.CS_MSEQ_STATE_OutBUS), 32'(ST_EXEC));
        checkOutput("trap.execNoPulse", 32'(busIf.CS_MSEQ_EXEC_Out), 32'd0);
        for (int i = 1; i <= TB_TIMEOUT; i++) begin
            nextCycle();
            checkOutput("trap.waitState", 32'(busIf.CS_MSEQ_STATE_OutBUS), 32'(ST_WAIT));
            checkOutput("trap.waitNoPulse", 32'(busIf.CS_MSEQ_EXEC_Out), 32'd0);
            checkOutput("trap.flagLow", 32'(busIf.CS_MSEQ_TIMEOUT_Out), 32'd0);
            checkOutput("trap.mpcHeld", 32'(busIf.CS_MSEQ_MPC_data_OutBUS), 32'(modelMpc));
        end
        nextCycle();
        applyStimulus(3'b000, 11'd0, 1'b0, 1'b0, 4'b0000, 32'd0, 1'b0);
        popped = expQ.pop_front();
        checkOutput("trap.fetchAgain", 32'(busIf.CS_MSEQ_STATE_OutBUS), 32'(ST_FETCH));
        checkOutput("trap.mpc", 32'(busIf.CS_MSEQ_MPC_data_OutBUS), 32'(popped));
        checkOutput("trap.flagHigh", 32'(busIf.CS_MSEQ_TIMEOUT_Out), 32'd1);
        checkOutput("trap.noPulse", 32'(busIf.CS_MSEQ_EXEC_Out), 32'd0);
        modelMpc = popped;
        runMicro("afterTrap", 3'b000, 11'd0, 1'b0, 1'b0, 4'b0000, 32'd0, 0, 11'd0);
        checkOutput("trap.flagSticky", 32'(busIf.CS_MSEQ_TIMEOUT_Out), 32'd1);
`else
        // Well past the watchdog budget: nothing may trap in this build
        runMicro("longWait", 3'b000, 11'd0, 1'b0, 1'b1, 4'b0000, 32'd0, 10, 11'd4);
        checkOutput("longWait.noTimeout", 32'(busIf.CS_MSEQ_TIMEOUT_Out), 32'd0);
`endif

        // Reset asserted while stalled in WAIT takes effect without a clock edge
        runMicro("jump1000", 3'b110, 11'd1000, 1'b0, 1'b0, 4'b0000, 32'd0, 0, 11'd1000);
        applyStimulus(3'b000, 11'd0, 1'b1, 1'b0, 4'b0000, 32'd0, 1'b0);
        nextCycle();
        nextCycle();
        checkOutput("midWait.state", 32'(busIf.CS_MSEQ_STATE_OutBUS), 32'(ST_WAIT));
        checkOutput("midWait.mpc", 32'(busIf.CS_MSEQ_MPC_data_OutBUS), 32'd1000);
        resetInLow = 1'b0;
        #1;
        checkOutput("midWaitReset.mpc",     32'(busIf.CS_MSEQ_MPC_data_OutBUS), 32'd0);
        checkOutput("midWaitReset.state",   32'(busIf.CS_MSEQ_STATE_OutBUS), 32'(ST_IDLE));
        checkOutput("midWaitReset.mirLoad", 32'(busIf.CS_MSEQ_MIRload_OutLow), 32'd1);
        checkOutput("midWaitReset.exec",    32'(busIf.CS_MSEQ_EXEC_Out), 32'd0);
        checkOutput("midWaitReset.timeout", 32'(busIf.CS_MSEQ_TIMEOUT_Out), 32'd0);
        checkOutput("scoreboardEmpty", 32'(expQ.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
